lfsr_rand_range: RTL and testbench

Parametrised Fibonacci LFSR random source with run-time seeding, stall control and lock-up protection. It adds a request/response engine that returns uniformly distributed values in [0, limit) by rejection sampling, with a bounded-retry fallback. The Snake game logic uses it for food placement (x/y cell draws) and any other bounded random choice. It replaces fixed-width, fixed-tap free-running generators.

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_rand_range_core.sv | 43 ++++
 rtl/lfsr_rand_range.sv | 168 ++++++++++++++++
 tb/tb_lfsr_rand_range.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random source: default tap masks, the
// request FSM encoding and the limit-to-mask helper.
package lfsr_pkg;

  // Maximal-length tap masks for the shift-left Fibonacci form used by
  // lfsr_core (bit i set means state[i] feeds the XOR).
  localparam logic [15:0] TAPS_16 = 16'hD008;      // x^16+x^15+x^13+x^4+1
  localparam logic [23:0] TAPS_24 = 24'hE1_0000;   // x^24+x^23+x^22+x^17+1
  localparam logic [31:0] TAPS_32 = 32'h8020_0003; // x^32+x^22+x^2+x+1

  // Draw engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_HOLD = 2'd2
  } fsm_state_e;

  // Smallest 2^k-1 that is >= lim-1. A zero limit wraps lim-1 to all
  // ones, which is exactly the full-range mask it stands for. Callers
  // zero-extend limits of up to 32 bits and truncate the result.
  function automatic logic [31:0] mask_from_limit(input logic [31:0] lim);
    logic [31:0] m;
    m = lim - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_rand_range_core.sv
// Fibonacci LFSR state register with seed loading and lock-up avoidance.
// A zero seed would freeze the register, so it is replaced by all ones.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_32)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             fb;

  // Next state: seed load wins over a shift step, otherwise hold.
  always_comb begin
    fb      = ^(state_q & TAPS);
    state_d = state_q;
    if (seed_load) begin
      state_d = (seed == '0) ? '1 : seed;
    end else if (step_en) begin
      state_d = {state_q[WIDTH-2:0], fb};
    end
  end

  // State register; reset value is all ones so the sequence never starts locked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_rand_range.sv
// Bounded random draw engine on top of lfsr_core. A request latches a limit,
// then candidates (low OUT_W bits of the LFSR, masked to the smallest
// power-of-two range covering the limit) are drawn until one falls below
// the limit or MAX_TRIES is exhausted, in which case cand - limit is used.
// Optional build macro: LFSR_STATS_EN enables the saturating reject counter.
module lfsr_rand_range
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_32),
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lfsr_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] random_out,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic [15:0]      reject_cnt
);

  localparam int              TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  fsm_state_e       st_q, st_d;
  logic [OUT_W-1:0] lim_q, lim_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;

  logic [WIDTH-1:0] state;
  logic             step_en;
  logic [OUT_W-1:0] cand;
  logic             cand_ok;

  // The LFSR is forced to advance while drawing so every retry sees a fresh value.
  assign step_en = lfsr_en | (st_q == ST_DRAW);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .step_en   (step_en),
    .seed_load (seed_load),
    .seed      (seed),
    .state     (state)
  );

  assign random_out = state;

  // Candidate and acceptance test against the latched limit.
  always_comb begin
    cand    = state[OUT_W-1:0] & mask_q;
    cand_ok = (lim_q == '0) || (lim_q == OUT_W'(1)) || (cand < lim_q);
  end

  // FSM next-state and registered-output logic.
  always_comb begin
    st_d        = st_q;
    lim_d       = lim_q;
    mask_d      = mask_q;
    tries_d     = tries_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (st_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          lim_d       = limit;
          mask_d      = OUT_W'(mask_from_limit(32'(limit)));
          tries_d     = '0;
          req_ready_d = 1'b0;
          st_d        = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (cand_ok) begin
          rsp_data_d  = cand;
          rsp_valid_d = 1'b1;
          st_d        = ST_HOLD;
        end else if (tries_q == LAST_TRY) begin
          // mask < 2*limit, so cand - limit is already inside the range.
          rsp_data_d  = cand - lim_q;
          rsp_valid_d = 1'b1;
          st_d        = ST_HOLD;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          st_d        = ST_IDLE;
        end
      end
      default: begin
        st_d        = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_IDLE;
      lim_q       <= '0;
      mask_q      <= '0;
      tries_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      st_q        <= st_d;
      lim_q       <= lim_d;
      mask_q      <= mask_d;
      tries_q     <= tries_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef LFSR_STATS_EN
  logic [15:0] rej_q;
  logic [15:0] rej_d;

  // Count every rejected candidate, including the one that triggers fallback.
  always_comb begin
    rej_d = rej_q;
    if ((st_q == ST_DRAW) && !cand_ok && (rej_q != 16'hFFFF)) begin
      rej_d = rej_q + 16'd1;
    end
  end

  // Reject counter register; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rej_q <= '0;
    end else begin
      rej_q <= rej_d;
    end
  end

  assign reject_cnt = rej_q;
`else
  assign reject_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_rand_range.sv
module tb_lfsr_rand_range;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lfsr_en = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed = 32'd0;
  logic [31:0] random_out;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  limit = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [15:0] reject_cnt;

  // second instance with a single try, for the fallback path
  logic        b_seed_load = 1'b0;
  logic [31:0] b_seed = 32'd0;
  logic [31:0] b_random_out;
  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic [7:0]  b_limit = 8'd0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b0;
  logic [7:0]  b_rsp_data;
  logic [15:0] b_reject_cnt;

  int total = 0;
  int bad = 0;
  logic [31:0] m_state = 32'hFFFF_FFFF;
  int exp_rej = 0;

  always #5 clk = ~clk;

  lfsr_rand_range dut (
    .clk(clk), .reset(reset), .lfsr_en(lfsr_en), .seed_load(seed_load),
    .seed(seed), .random_out(random_out), .req_valid(req_valid),
    .req_ready(req_ready), .limit(limit), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .reject_cnt(reject_cnt)
  );

  lfsr_rand_range #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .lfsr_en(lfsr_en), .seed_load(b_seed_load),
    .seed(b_seed), .random_out(b_random_out), .req_valid(b_req_valid),
    .req_ready(b_req_ready), .limit(b_limit), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .reject_cnt(b_reject_cnt)
  );

  // x^32+x^22+x^2+x+1, shift left, feedback into bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  function automatic logic [15:0] rej_expect(input int n);
`ifdef LFSR_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  // Reference draw: result, DRAW cycles used, rejections seen.
  function automatic void model_draw(input logic [31:0] s0, input logic [7:0] lim,
                                     input int maxt, output logic [7:0] d,
                                     output int ncyc, output int nrej);
    logic [31:0] s;
    int mk;
    logic [7:0] cand;
    if (lim == 0) mk = 255;
    else begin
      mk = 0;
      while (mk < int'(lim) - 1) mk = mk * 2 + 1;
    end
    s = s0; d = 8'd0; ncyc = 0; nrej = 0;
    for (int t = 0; t < maxt; t++) begin
      ncyc = t + 1;
      cand = s[7:0] & 8'(mk);
      if (lim == 0 || lim == 1 || cand < lim) begin
        d = cand;
        return;
      end
      nrej++;
      if (t == maxt - 1) begin
        d = cand - lim;
        return;
      end
      s = lfsr_step(s);
    end
  endfunction

  // One clock; the model state follows the inputs seen at the edge.
  task automatic tick;
    @(posedge clk);
    if (!reset) m_state = 32'hFFFF_FFFF;
    else if (seed_load) m_state = (seed == 32'd0) ? 32'hFFFF_FFFF : seed;
    else if (lfsr_en) m_state = lfsr_step(m_state);
    #1;
  endtask

  // Full transaction on the main instance; returns observations only.
  task automatic run_req(input logic [7:0] lim, input bit bp,
                         output logic [31:0] s_draw, output logic [7:0] data,
                         output int lat, output bit stable_ok, output bit tmo);
    s_draw = 32'd0; data = 8'd0; lat = 0; stable_ok = 1'b1; tmo = 1'b0;
    for (int w = 0; w < 10 && !req_ready; w++) tick;
    if (!req_ready) begin tmo = 1'b1; return; end
    req_valid = 1'b1; limit = lim; rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    limit = 8'($urandom);
    s_draw = m_state;
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick; lat++; end
    if (!rsp_valid) begin tmo = 1'b1; return; end
    data = rsp_data;
    for (int n = 0; n < 50; n++) begin
      rsp_ready = (bp && n < 49) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick;
      if (rsp_ready) break;
      if (!rsp_valid || rsp_data !== data) stable_ok = 1'b0;
    end
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0) stable_ok = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; lfsr_en = 1'b1;
    tick; tick;
    total++; if (random_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_state got=%h exp=ffffffff", random_out); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 8'd0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=00", rsp_data); end
    total++; if (reject_cnt !== 16'd0) begin bad++; $display("FAIL rst_reject_cnt got=%h exp=0000", reject_cnt); end
    reset = 1'b1; exp_rej = 0;
    #1;
    total++; if (random_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rel_state got=%h exp=ffffffff", random_out); end
    tick;
    total++; if (random_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL first_step got=%h exp=fffffffe", random_out); end
    $display("test_reset done");
  endtask

  task automatic test_lfsr_seq;
    for (int i = 0; i < 1000; i++) begin
      tick;
      total++;
      if (random_out !== m_state || random_out == 32'd0) begin
        bad++; $display("FAIL lfsr_seq cyc=%0d got=%h exp=%h", i, random_out, m_state);
      end
    end
    $display("test_lfsr_seq done");
  endtask

  task automatic test_seed;
    lfsr_en = 1'b0;
    seed = 32'd0; seed_load = 1'b1; tick; seed_load = 1'b0;
    total++; if (random_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL seed_zero got=%h exp=ffffffff", random_out); end
    tick;
    total++; if (random_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hold_no_en got=%h exp=ffffffff", random_out); end
    seed = 32'h0000_0001; seed_load = 1'b1; tick; seed_load = 1'b0;
    total++; if (random_out !== 32'h0000_0001) begin bad++; $display("FAIL seed_one got=%h exp=00000001", random_out); end
    lfsr_en = 1'b1; tick;
    // bit0 is a tap, so feedback is 1: {0..01, 1} = 3
    total++; if (random_out !== 32'h0000_0003) begin bad++; $display("FAIL seed_step got=%h exp=00000003", random_out); end
    $display("test_seed done");
  endtask

  task automatic test_limit_one;
    logic [31:0] s; logic [7:0] d; int lat; bit st, tmo;
    run_req(8'd1, 1'b0, s, d, lat, st, tmo);
    total++; if (tmo || lat != 2) begin bad++; $display("FAIL lim1_latency got=%0d exp=2 tmo=%0d", lat, tmo); end
    total++; if (d !== 8'd0) begin bad++; $display("FAIL lim1_data got=%h exp=00", d); end
    total++; if (!st) begin bad++; $display("FAIL lim1_handshake got=0 exp=1"); end
    total++; if (reject_cnt !== rej_expect(exp_rej)) begin bad++; $display("FAIL lim1_reject_cnt got=%h exp=%h", reject_cnt, rej_expect(exp_rej)); end
    $display("test_limit_one done lat=%0d data=%h", lat, d);
  endtask

  task automatic test_limit_zero;
    logic [31:0] s; logic [7:0] d; int lat; bit st, tmo;
    run_req(8'd0, 1'b0, s, d, lat, st, tmo);
    total++; if (tmo || lat != 2) begin bad++; $display("FAIL lim0_latency got=%0d exp=2 tmo=%0d", lat, tmo); end
    total++; if (d !== s[7:0]) begin bad++; $display("FAIL lim0_data got=%h exp=%h", d, s[7:0]); end
    $display("test_limit_zero done data=%h", d);
  endtask

  task automatic test_limit_200;
    logic [31:0] s; logic [7:0] d, ed; int lat, ncyc, nrej; bit st, tmo;
    for (int i = 0; i < 4000; i++) begin
      run_req(8'd200, 1'b1, s, d, lat, st, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL lim200_timeout req=%0d got=timeout exp=response", i); break; end
      model_draw(s, 8'd200, 8, ed, ncyc, nrej);
      exp_rej += nrej;
      if (d !== ed || d >= 8'd200) begin bad++; $display("FAIL lim200_data req=%0d got=%0d exp=%0d", i, d, ed); end
      total++; if (lat != 1 + ncyc) begin bad++; $display("FAIL lim200_latency req=%0d got=%0d exp=%0d", i, lat, 1 + ncyc); end
      total++; if (!st) begin bad++; $display("FAIL lim200_stable req=%0d got=0 exp=1", i); end
    end
    total++; if (reject_cnt !== rej_expect(exp_rej)) begin bad++; $display("FAIL lim200_reject_cnt got=%h exp=%h", reject_cnt, rej_expect(exp_rej)); end
    $display("test_limit_200 done rejections=%0d", exp_rej);
  endtask

  task automatic test_fallback;
    int lat;
    lfsr_en = 1'b0;
    total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL fb_ready got=%b exp=1", b_req_ready); end
    b_seed = 32'h0000_00F0; b_seed_load = 1'b1; tick; b_seed_load = 1'b0;
    b_req_valid = 1'b1; b_limit = 8'd200; tick; b_req_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin tick; lat++; end
    total++; if (lat != 2) begin bad++; $display("FAIL fb_latency got=%0d exp=2", lat); end
    // 0xF0=240 >= 200 with a single try: 240-200 = 40
    total++; if (b_rsp_data !== 8'd40) begin bad++; $display("FAIL fb_data got=%0d exp=40", b_rsp_data); end
    total++; if (b_reject_cnt !== rej_expect(1)) begin bad++; $display("FAIL fb_reject_cnt got=%h exp=%h", b_reject_cnt, rej_expect(1)); end
    b_rsp_ready = 1'b1; tick; b_rsp_ready = 1'b0;
    total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL fb_release got=%b exp=0", b_rsp_valid); end
    lfsr_en = 1'b1;
    $display("test_fallback done data=%0d", b_rsp_data);
  endtask

  task automatic test_reset_mid_draw;
    logic [31:0] s; logic [7:0] d; int lat; bit st, tmo;
    seed = 32'h0000_00F0; seed_load = 1'b1; tick; seed_load = 1'b0;
    req_valid = 1'b1; limit = 8'd200; tick; req_valid = 1'b0;
    // now drawing from 0x1E0: low byte 0xE0 is rejected
    total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL draw_busy got=%b%b exp=00", req_ready, rsp_valid); end
    reset = 1'b0; #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL draw_rst_hs got=%b%b exp=01", rsp_valid, req_ready); end
    total++; if (random_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL draw_rst_state got=%h exp=ffffffff", random_out); end
    exp_rej = 0;
    tick; reset = 1'b1;
    run_req(8'd1, 1'b0, s, d, lat, st, tmo);
    total++; if (tmo || lat != 2 || d !== 8'd0) begin bad++; $display("FAIL draw_rst_next got=lat%0d/%h exp=lat2/00", lat, d); end
    $display("test_reset_mid_draw done");
  endtask

  task automatic test_reset_mid_hold;
    logic [31:0] s, s2; logic [7:0] d, ed; int lat, ncyc, nrej; bit st, tmo;
    req_valid = 1'b1; limit = 8'd0; tick; req_valid = 1'b0;
    s = m_state;
    tick;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== s[7:0]) begin bad++; $display("FAIL hold_rsp got=%b/%h exp=1/%h", rsp_valid, rsp_data, s[7:0]); end
    seed = 32'h1234_5678; seed_load = 1'b1; tick; seed_load = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== s[7:0]) begin bad++; $display("FAIL hold_seed_data got=%b/%h exp=1/%h", rsp_valid, rsp_data, s[7:0]); end
    total++; if (random_out !== 32'h1234_5678) begin bad++; $display("FAIL hold_seed_state got=%h exp=12345678", random_out); end
    reset = 1'b0; #1;
    total++; if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || req_ready !== 1'b1) begin bad++; $display("FAIL hold_rst got=%b/%h/%b exp=0/00/1", rsp_valid, rsp_data, req_ready); end
    total++; if (random_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hold_rst_state got=%h exp=ffffffff", random_out); end
    exp_rej = 0;
    tick; reset = 1'b1;
    run_req(8'd200, 1'b0, s2, d, lat, st, tmo);
    model_draw(s2, 8'd200, 8, ed, ncyc, nrej);
    exp_rej += nrej;
    total++; if (tmo || d !== ed || lat != 1 + ncyc) begin bad++; $display("FAIL hold_rst_next got=%0d/lat%0d exp=%0d/lat%0d", d, lat, ed, 1 + ncyc); end
    total++; if (reject_cnt !== rej_expect(exp_rej)) begin bad++; $display("FAIL hold_rst_reject_cnt got=%h exp=%h", reject_cnt, rej_expect(exp_rej)); end
    $display("test_reset_mid_hold done");
  endtask

  initial begin
    test_reset;
    test_lfsr_seq;
    test_seed;
    test_limit_one;
    test_limit_zero;
    test_limit_200;
    test_fallback;
    test_reset_mid_draw;
    test_reset_mid_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
